fir_avg_decim_sink: RTL and testbench

- Receiving end of the 4-tap average filter output (24-bit signed `dout`, one sample per cycle when valid).
- Decimates the stream by DECIM, saturates each kept sample to OUT_W signed bits, and buffers results in a small first-word-fall-through FIFO.
- Presents the FIFO to the downstream consumer with a valid/ready handshake.
- Sits between the filter and the sample consumer (DMA/packetiser).

---
 rtl/fir_avg_decim_sink.sv | 143 ++++++++++++++
 tb/tb_fir_avg_decim_sink.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_avg_decim_sink.sv
// fir_avg_decim_sink
//   Receiving end of the 4-tap average filter. Keeps 1 of every DECIM valid
//   input samples, saturates each kept sample to OUT_W signed bits and
//   buffers it in a first-word-fall-through FIFO that drains to the
//   downstream consumer.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   din       in   IN_W signed filter sample
//   din_vld   in   din valid this cycle (no backpressure to the filter)
//   dout      out  OUT_W signed head-of-FIFO sample (holds last value when empty)
//   dout_vld  out  FIFO non-empty
//   dout_rdy  in   consumer accepts dout this cycle
//   level     out  FIFO occupancy, 0..DEPTH
//   sat_cnt   out  16-bit saturating count of saturated kept samples
//                  (present only when FIR_DECIM_SAT_CNT_EN is defined)
//   ovf       out  sticky: a kept sample was dropped because the FIFO was full
//
// Optional feature macro: FIR_DECIM_SAT_CNT_EN adds the sat_cnt port/counter.
//
// Handshake: a sample transfers on every rising edge where dout_vld and
// dout_rdy are both high. dout_vld never waits on dout_rdy, and dout_rdy is
// ignored while dout_vld is low.

module fir_avg_decim_sink #(
    parameter int DECIM = 4,
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          din,
    input  logic                     din_vld,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_vld,
    input  logic                     dout_rdy,
    output logic [$clog2(DEPTH):0]   level,
`ifdef FIR_DECIM_SAT_CNT_EN
    output logic [15:0]              sat_cnt,
`endif
    output logic                     ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0]  phase;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OUT_W-1:0] mem [DEPTH];

    // In range when all bits from the sign bit down to bit OUT_W-1 agree.
    logic             in_range;
    logic             saturated;
    logic [OUT_W-1:0] sat_din;

    assign in_range = (din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){din[IN_W-1]}});

    always_comb begin
        sat_din   = din[OUT_W-1:0];
        saturated = 1'b0;
        if (!in_range) begin
            saturated = 1'b1;
            sat_din   = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    logic             kept;
    logic             full;
    logic             pop;
    logic             push;
    logic [LVL_W-1:0] level_after_pop;
    logic [LVL_W-1:0] level_next;
    logic [PTR_W-1:0] rd_next;

    assign kept            = din_vld && (phase == '0);
    assign full            = (level == LVL_W'(DEPTH));
    assign pop             = dout_vld && dout_rdy;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push            = kept && (!full || pop);
    assign level_after_pop = level - LVL_W'(pop);
    assign level_next      = level_after_pop + LVL_W'(push);
    assign rd_next         = rd_ptr + PTR_W'(pop);

    // Storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sat_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (din_vld) begin
                phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_next;
            level    <= level_next;
            dout_vld <= (level_next != '0);
            // Registered FWFT head: if nothing stays behind after the pop, the
            // new head (if any) is the sample being pushed right now;
            // otherwise it is the stored entry at the advanced read pointer.
            // With nothing left and nothing pushed, dout keeps its last value.
            if (level_after_pop == '0) begin
                if (push) begin
                    dout <= sat_din;
                end
            end else begin
                dout <= mem[rd_next];
            end
            if (kept && !push) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef FIR_DECIM_SAT_CNT_EN
    // Counts saturated kept samples whether or not the FIFO accepted them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (kept && saturated && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_avg_decim_sink.sv
module tb_fir_avg_decim_sink;

  localparam int DECIM = 4;
  localparam int IN_W  = 24;
  localparam int OUT_W = 16;
  localparam int DEPTH = 8;
  localparam int MAXV  = (1 << (OUT_W - 1)) - 1;
  localparam int MINV  = -(1 << (OUT_W - 1));

  // ---------------- clock / reset / DUT ----------------
  logic                    clk;
  logic                    rst;
  logic [IN_W-1:0]         din;
  logic                    din_vld;
  logic [OUT_W-1:0]        dout;
  logic                    dout_vld;
  logic                    dout_rdy;
  logic [$clog2(DEPTH):0]  level;
  logic                    ovf;
`ifdef FIR_DECIM_SAT_CNT_EN
  logic [15:0]             sat_cnt;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fir_avg_decim_sink #(
    .DECIM(DECIM),
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .DEPTH(DEPTH)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .dout    (dout),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .level   (level),
`ifdef FIR_DECIM_SAT_CNT_EN
    .sat_cnt (sat_cnt),
`endif
    .ovf     (ovf)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic signed [OUT_W-1:0] exp_q[$];   // model FIFO contents, head first
  logic signed [OUT_W-1:0] got_q[$];   // samples the DUT handed over
  int                      m_vcount;   // valid inputs seen since reset
  bit                      m_ovf;
  int                      m_last;     // value dout must show
  int                      m_sat;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat_of(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Applies one clock edge of the specified behaviour to the model.
  task automatic model_edge(input logic signed [IN_W-1:0] d, input logic v,
                            input logic r, input logic rs);
    int  dv;
    bit  keep;
    if (rs) begin
      exp_q.delete();
      m_vcount = 0;
      m_ovf    = 0;
      m_last   = 0;
      m_sat    = 0;
      return;
    end
    dv   = int'(d);
    keep = v && (m_vcount % DECIM == 0);
    if (v) m_vcount++;
    if (r && exp_q.size() > 0) void'(exp_q.pop_front());
    if (keep) begin
      if (sat_of(dv) != dv && m_sat < 16'hFFFF) m_sat++;
      if (exp_q.size() < DEPTH) exp_q.push_back(OUT_W'(sat_of(dv)));
      else m_ovf = 1;
    end
    if (exp_q.size() > 0) m_last = int'(exp_q[0]);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic signed [IN_W-1:0] d, input logic v,
                       input logic r, input logic rs);
    din      = d;
    din_vld  = v;
    dout_rdy = r;
    rst      = rs;
    if (!rs && dout_vld && r) got_q.push_back(dout);
    @(posedge clk);
    model_edge(d, v, r, rs);
    @(negedge clk);
    chk("dout_vld", {31'b0, dout_vld}, (exp_q.size() > 0) ? 1 : 0);
    chk("level", 32'(level), exp_q.size());
    chk("dout", $signed(dout), m_last);
    chk("ovf", {31'b0, ovf}, m_ovf ? 1 : 0);
`ifdef FIR_DECIM_SAT_CNT_EN
    chk("sat_cnt", {16'b0, sat_cnt}, m_sat);
`endif
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 1'b0, 1'b1);
  endtask

  // One kept sample followed by DECIM-1 non-kept random fillers.
  task automatic kept_then_fill(input int val, input logic r);
    cycle(IN_W'(val), 1'b1, r, 1'b0);
    for (int k = 1; k < DECIM; k++) cycle(IN_W'($urandom()), 1'b1, r, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int sat_in[5]  = '{40000, -40000, 32767, -32768, 100};
  int sat_exp[5] = '{32767, -32768, 32767, -32768, 100};
  logic gap_v[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    din = '0; din_vld = 1'b0; dout_rdy = 1'b0; rst = 1'b1;
    m_vcount = 0; m_ovf = 0; m_last = 0; m_sat = 0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("reset_level", 32'(level), 0);
    chk("reset_dout", $signed(dout), 0);

    // Ramp 0..15, always ready
    got_q.delete();
    for (int i = 0; i < 16; i++) cycle(IN_W'(i), 1'b1, 1'b1, 1'b0);
    chk("ramp_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("ramp_out", int'(got_q[i]), i * 4);
    chk("ramp_ovf", {31'b0, ovf}, 0);

    // Gapped valid: kept are 1st (10) and 5th (17) valid samples
    do_reset();
    got_q.delete();
    for (int i = 0; i < 8; i++) cycle(IN_W'(10 + i), gap_v[i], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1, 1'b0);
    chk("gap_count", got_q.size(), 2);
    chk("gap_first", int'(got_q[0]), 10);
    chk("gap_second", int'(got_q[1]), 17);

    // Saturation
    do_reset();
    got_q.delete();
    for (int i = 0; i < 5; i++) kept_then_fill(sat_in[i], 1'b1);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1, 1'b0);
    chk("sat_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("sat_out", int'(got_q[i]), sat_exp[i]);
`ifdef FIR_DECIM_SAT_CNT_EN
    chk("sat_cnt_total", {16'b0, sat_cnt}, 2);
`endif

    // Overflow: 10 kept samples into a stalled FIFO, then drain
    do_reset();
    for (int i = 1; i <= 10; i++) kept_then_fill(i, 1'b0);
    chk("ovf_level", 32'(level), 8);
    chk("ovf_dout", $signed(dout), 1);
    chk("ovf_flag", {31'b0, ovf}, 1);
    got_q.delete();
    for (int i = 0; i < 12; i++) cycle('0, 1'b0, 1'b1, 1'b0);
    chk("ovf_drain_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("ovf_drain", int'(got_q[i]), i + 1);
    chk("ovf_sticky", {31'b0, ovf}, 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 8; i++) kept_then_fill(i, 1'b0);
    chk("full_level", 32'(level), 8);
    got_q.delete();
    cycle(IN_W'(99), 1'b1, 1'b1, 1'b0);
    chk("pp_level", 32'(level), 8);
    chk("pp_ovf", {31'b0, ovf}, 0);
    for (int i = 0; i < 12; i++) cycle('0, 1'b0, 1'b1, 1'b0);
    chk("pp_count", got_q.size(), 9);
    for (int i = 0; i < 8; i++) chk("pp_order", int'(got_q[i]), i + 1);
    chk("pp_last", int'(got_q[8]), 99);

    // Reset mid-operation
    do_reset();
    for (int i = 1; i <= 5; i++) kept_then_fill(100 + i, 1'b0);
    chk("mid_level", 32'(level), 5);
    do_reset();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_vld", {31'b0, dout_vld}, 0);
    chk("mid_rst_dout", $signed(dout), 0);
    chk("mid_rst_ovf", {31'b0, ovf}, 0);
    cycle(IN_W'(77), 1'b1, 1'b0, 1'b0);
    chk("mid_restart", $signed(dout), 77);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic signed [IN_W-1:0] d;
      logic v, r, rs;
      if ($urandom_range(0, 3) == 0) d = IN_W'($urandom());
      else d = IN_W'($urandom_range(0, 2 * MAXV) - MAXV);
      v  = ($urandom_range(0, 3) != 0);
      r  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                : ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 299) == 0);
      cycle(d, v, r, rs);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the run is a fixed number of cycles, so this only fires on a hang.
  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
